// File: rtl/voice_mixer_pkg.sv
// voice_mixer_pkg: shared FSM state type, accumulator sizing and output reduction.
// Contents: state_e (IDLE/ISSUE/WAIT/ACC/OUT), acc_width(), reduce_acc().
// Build option: VOICE_MIXER_SAT_EN selects saturating instead of wrapping reduction.
package voice_mixer_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ACC, OUT} state_e;
  localparam int MAX_W = 128;
  typedef logic signed [MAX_W-1:0] wide_t;
  // Signed accumulator holds NUM_VOICES full-scale magnitudes of either sign.
  function automatic int acc_width(int cw, int nv);
    return cw + $clog2(nv) + 1;
  endfunction
  // Result is meaningful in its low cw bits.
  function automatic wide_t reduce_acc(wide_t a, int cw);
`ifdef VOICE_MIXER_SAT_EN
    wide_t hi, lo;
    hi = (wide_t'(1) <<< (cw - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (cw - 1));
    return a > hi ? hi : (a < lo ? lo : a);
`else
    return (a <<< (MAX_W - cw)) >>> (MAX_W - cw);
`endif
  endfunction
endpackage

// File: rtl/voice_mixer_if.sv
// voice_mixer_if: handshake bundle between voice_mixer and the sequential multiplier.
// Signals: a, b (operands), trigger (start), ready (idle), done (result pulse), y (product).
// Modports: master = mixer side, slave = multiplier side.
interface voice_mixer_if #(parameter int C_WIDTH = 32);
  logic [C_WIDTH-1:0] a, b, y;
  logic trigger, ready, done;
  modport master (output a, b, trigger, input ready, done, y);
  modport slave (input a, b, trigger, output ready, done, y);
endinterface

// File: rtl/voice_mixer_accumulator.sv
// mix_accumulator: signed accumulator of unsigned product magnitudes with final reduction.
// Ports: clk, rst_n (async active-low), clr_i (zero), add_i (accumulate), neg_i (subtract),
//        mag_i (product magnitude), next_mix_o (reduced value of the next accumulator state).
// Build option: VOICE_MIXER_SAT_EN clamps instead of wrapping (see reduce_acc).
module mix_accumulator
  import voice_mixer_pkg::*;
#(
  parameter int C_WIDTH    = 32,
  parameter int NUM_VOICES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               add_i,
  input  logic               neg_i,
  input  logic [C_WIDTH-1:0] mag_i,
  output logic [C_WIDTH-1:0] next_mix_o
);
  localparam int AW = acc_width(C_WIDTH, NUM_VOICES);
  logic signed [AW-1:0] acc_q, acc_d, mag_x;
  wide_t wide_d;
  assign mag_x = $signed({{(AW-C_WIDTH){1'b0}}, mag_i});
  assign acc_d = clr_i ? '0 : !add_i ? acc_q : neg_i ? acc_q - mag_x : acc_q + mag_x;
  assign wide_d = acc_d;
  assign next_mix_o = C_WIDTH'(reduce_acc(wide_d, C_WIDTH));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) acc_q <= '0;
    else acc_q <= acc_d;
endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: gain-scaled sum of NUM_VOICES signed samples via a shared unsigned multiplier.
// Ports: ctl_clk, reset (async active-low), frame_valid/voice_sample/voice_gain (frame in),
//        mul (voice_mixer_if master: handshake to multiplier), mix_out/mix_valid (result),
//        busy (frame in progress), overrun (sticky: frame dropped while busy).
// Build option: VOICE_MIXER_SAT_EN saturates the mixed sample instead of wrapping.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int C_WIDTH     = 32,
  parameter int FIXED_POINT = 8,
  parameter int NUM_VOICES  = 8
) (
  input  logic                          ctl_clk,
  input  logic                          reset,
  input  logic                          frame_valid,
  input  logic [NUM_VOICES*C_WIDTH-1:0] voice_sample,
  input  logic [NUM_VOICES*C_WIDTH-1:0] voice_gain,
  voice_mixer_if.master                 mul,
  output logic [C_WIDTH-1:0]            mix_out,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          overrun
);
  localparam int IW = $clog2(NUM_VOICES);
  typedef logic [NUM_VOICES-1:0][C_WIDTH-1:0] vec_t;
  if (NUM_VOICES < 2 || FIXED_POINT >= C_WIDTH) begin : g_bad_cfg
    $error("voice_mixer: unsupported parameters");
  end
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  vec_t samp_q, samp_d, gain_q, gain_d, samp_in, gain_in;
  logic [C_WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, prod_q, prod_d, mix_out_q, mix_out_d;
  logic [C_WIDTH-1:0] nsamp, acc_mix;
  logic neg_q, neg_d, mix_valid_q, mix_valid_d, overrun_q, overrun_d;
  logic accept, last, step, load;
  assign samp_in = voice_sample;
  assign gain_in = voice_gain;
  always_comb begin
    accept = state_q == IDLE && frame_valid;
    last = idx_q == IW'(NUM_VOICES - 1);
    step = state_q == ACC && !last;
    load = accept || step;
    idx_d = accept ? '0 : step ? idx_q + 1'b1 : idx_q;
    samp_d = accept ? samp_in : samp_q;
    gain_d = accept ? gain_in : gain_q;
    // Operands for the voice about to be issued; sign is reapplied after the multiply.
    nsamp = samp_d[idx_d];
    mul_a_d = load ? (nsamp[C_WIDTH-1] ? -nsamp : nsamp) : mul_a_q;
    mul_b_d = load ? gain_d[idx_d] : mul_b_q;
    prod_d = state_q == WAIT && mul.done ? mul.y : prod_q;
    neg_d = state_q == WAIT && mul.done ? samp_q[idx_q][C_WIDTH-1] : neg_q;
    // Result registers load at the end of the last ACC so mix_valid is seen during OUT.
    mix_valid_d = state_q == ACC && last;
    mix_out_d = mix_valid_d ? acc_mix : mix_out_q;
    overrun_d = frame_valid ? state_q != IDLE : overrun_q;
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = frame_valid ? ISSUE : IDLE;
      ISSUE:   state_d = mul.ready ? WAIT : ISSUE;
      WAIT:    state_d = mul.done ? ACC : WAIT;
      ACC:     state_d = last ? OUT : ISSUE;
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ctl_clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      samp_q <= '0;
      gain_q <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      prod_q <= '0;
      neg_q <= 1'b0;
      mix_out_q <= '0;
      mix_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      samp_q <= samp_d;
      gain_q <= gain_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      prod_q <= prod_d;
      neg_q <= neg_d;
      mix_out_q <= mix_out_d;
      mix_valid_q <= mix_valid_d;
      overrun_q <= overrun_d;
    end
  mix_accumulator #(.C_WIDTH(C_WIDTH), .NUM_VOICES(NUM_VOICES)) u_acc (
    .clk       (ctl_clk),
    .rst_n     (reset),
    .clr_i     (accept),
    .add_i     (state_q == ACC),
    .neg_i     (neg_q),
    .mag_i     (prod_q),
    .next_mix_o(acc_mix)
  );
  // Trigger only while the multiplier reports idle; it drops at once on reset.
  assign mul.trigger = state_q == ISSUE && mul.ready;
  assign mul.a = mul_a_q;
  assign mul.b = mul_b_q;
  assign mix_out = mix_out_q;
  assign mix_valid = mix_valid_q;
  assign busy = state_q != IDLE;
  assign overrun = overrun_q;
endmodule
